// File: rtl/tx_seq_pkg.sv
// Shared definitions for the TX sequence controller: FSM state encoding,
// default parameter values and small helpers used by the controller.
package tx_seq_pkg;

  // Default parameter values for tx_seq_cntrl
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_PERIOD    = 4096;
  localparam int DEF_START_CNT = 3000;
  localparam int DEF_NUM_WORDS = 4;
  localparam int DEF_SEED      = 0;

  // FSM state encoding (plain constants for compatibility with older tools)
  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // True for every state in which the sequencer owns the frame
  function automatic logic st_is_busy(input logic [ST_W-1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage : tx_seq_pkg

// File: rtl/tx_period_cnt.sv
// Frame counter: counts 0..PERIOD-1 and wraps, can be cleared, and can be
// held at its terminal value while a burst overruns the frame.
module tx_period_cnt
  import tx_seq_pkg::*;
#(
  parameter  int PERIOD = DEF_PERIOD,
  localparam int CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_step,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);

  // Advance, wrap, hold at the terminal count, or clear the frame count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_step) begin
      if (w_at_max) begin
        r_cnt <= i_freeze ? r_cnt : '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cnt    = r_cnt;
  assign o_at_max = w_at_max;

endmodule : tx_period_cnt

// File: rtl/tx_seq_cntrl.sv
// TX sequence controller: frames time into PERIOD-cycle windows, emits an
// SPI reset pulse at the start of each frame and a NUM_WORDS burst of
// incrementing words (with valid/ready handshake) from count START_CNT.
module tx_seq_cntrl
  import tx_seq_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                PERIOD    = DEF_PERIOD,
  parameter int                START_CNT = DEF_START_CNT,
  parameter int                NUM_WORDS = DEF_NUM_WORDS,
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic              start,
  input  logic              tx_ready,
  output logic              spi_reset,
  output logic [DATA_W-1:0] tx_data,
  output logic              dv,
  output logic              busy,
  output logic              burst_done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int NW_W  = $clog2(NUM_WORDS + 1);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_CNT);
  localparam logic [NW_W-1:0]  NW_LAST   = NW_W'(NUM_WORDS - 1);

  // FSM and control registers
  logic [ST_W-1:0]   r_state;
  logic              r_mode_lat;   // mode captured when leaving IDLE
  logic              r_shot_done;  // one-shot frame has finished its burst
  logic              r_abort;      // en dropped during SEND, finish current word
  logic              r_frozen;     // frame counter held at its last value
  logic [NW_W-1:0]   r_nword;      // words accepted in the current burst
  logic [DATA_W-1:0] r_wcnt;       // running word counter, survives frames

  // Output registers
  logic              r_spi_reset;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_dv;
  logic              r_busy;
  logic              r_burst_done;
  logic              r_overrun;

  // Combinational control
  logic [ST_W-1:0]   w_next_state;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_at_max;
  logic              w_at_start;
  logic              w_accept;
  logic              w_last;
  logic              w_stop;
  logic              w_cnt_clr;
  logic              w_cnt_step;
  logic              w_cnt_freeze;
  logic              w_hold_max;
  logic              w_burst_ok;

  assign w_at_start = (w_cnt == CNT_START);
  assign w_accept   = (r_state == ST_SEND) && r_dv && tx_ready;
  assign w_last     = (r_nword == NW_LAST);
  assign w_stop     = !en || r_abort;
  assign w_burst_ok = w_accept && w_last && !w_stop;

  // Next-state selection; exits from SEND only happen on an accepted word
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en && (!mode || start)) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en) begin
          w_next_state = ST_IDLE;
        end else if (w_at_start && !(r_mode_lat && r_shot_done)) begin
          w_next_state = ST_SEND;
        end else if (r_mode_lat && r_shot_done && w_at_max) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_SEND: begin
        if (!w_accept) begin
          w_next_state = ST_SEND;
        end else if (w_stop) begin
          w_next_state = ST_IDLE;
        end else if (!w_last) begin
          w_next_state = ST_SEND;
        end else if (r_mode_lat && w_at_max) begin
          // one-shot burst that overran the frame ends the shot right here
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Frame counter clears on the way to IDLE and freezes while SEND persists
  assign w_cnt_clr    = (w_next_state == ST_IDLE);
  assign w_cnt_step   = (r_state != ST_IDLE);
  assign w_cnt_freeze = (r_state == ST_SEND) && (w_next_state == ST_SEND);
  assign w_hold_max   = w_cnt_freeze && w_at_max;

  tx_period_cnt #(
    .PERIOD (PERIOD)
  ) u_period_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_cnt_clr),
    .i_step   (w_cnt_step),
    .i_freeze (w_cnt_freeze),
    .o_cnt    (w_cnt),
    .o_at_max (w_at_max)
  );

  // State register, busy flag and the mode captured at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_mode_lat <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= st_is_busy(w_next_state);
      if ((r_state == ST_IDLE) && (w_next_state == ST_RUN)) begin
        r_mode_lat <= mode;
      end
    end
  end

  // Burst bookkeeping flags: one-shot completion and pending en-abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shot_done <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      if (w_next_state == ST_IDLE) begin
        r_shot_done <= 1'b0;
      end else if (w_burst_ok) begin
        r_shot_done <= 1'b1;
      end
      // r_abort feeds w_stop, so it stays set until SEND is left
      r_abort <= (r_state == ST_SEND) && (w_next_state == ST_SEND) && w_stop;
    end
  end

  // Frame-level pulses: SPI reset after count 0, overrun on first frozen cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spi_reset <= 1'b0;
      r_frozen    <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_spi_reset <= (r_state != ST_IDLE) && (w_cnt == '0);
      r_frozen    <= w_hold_max;
      r_overrun   <= w_hold_max && !r_frozen;
    end
  end

  // Word datapath: present the word counter, advance on each accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt       <= SEED;
      r_nword      <= '0;
      r_tx_data    <= '0;
      r_dv         <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= w_burst_ok;
      if ((r_state == ST_RUN) && (w_next_state == ST_SEND)) begin
        r_dv      <= 1'b1;
        r_tx_data <= r_wcnt;
        r_nword   <= '0;
      end else if (w_accept) begin
        r_wcnt  <= r_wcnt + DATA_W'(1);
        r_nword <= r_nword + NW_W'(1);
        if (w_next_state == ST_SEND) begin
          r_tx_data <= r_wcnt + DATA_W'(1);
        end else begin
          r_dv      <= 1'b0;
          r_tx_data <= '0;
        end
      end
    end
  end

  assign spi_reset  = r_spi_reset;
  assign tx_data    = r_tx_data;
  assign dv         = r_dv;
  assign busy       = r_busy;
  assign burst_done = r_burst_done;
  assign overrun    = r_overrun;

endmodule : tx_seq_cntrl

// File: tb/tb_tx_seq_cntrl.sv
// Scoreboard bench for tx_seq_cntrl (DATA_W=8, PERIOD=16, START_CNT=4,
// NUM_WORDS=3, SEED=F0). Stimulus pushes timed expected events; a monitor
// thread pops and compares every event the DUT produces.
module tb_tx_seq_cntrl;

  localparam int EV_SPI  = 0;
  localparam int EV_OVR  = 1;
  localparam int EV_WORD = 2;
  localparam int EV_BD   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       start;
  logic       tx_ready;
  logic       spi_reset;
  logic [7:0] tx_data;
  logic       dv;
  logic       busy;
  logic       burst_done;
  logic       overrun;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  base;

  tx_seq_cntrl #(
    .DATA_W    (8),
    .PERIOD    (16),
    .START_CNT (4),
    .NUM_WORDS (3),
    .SEED      (8'hF0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .start      (start),
    .tx_ready   (tx_ready),
    .spi_reset  (spi_reset),
    .tx_data    (tx_data),
    .dv         (dv),
    .busy       (busy),
    .burst_done (burst_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_SPI:  return "spi_reset";
      EV_OVR:  return "overrun";
      EV_WORD: return "word";
      EV_BD:   return "burst_done";
      default: return "unknown";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic exp_ev(input int kind, input logic [7:0] d, input int at);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.at   = at;
    sbq.push_back(e);
  endtask

  // Undisturbed frame starting at cycle b (count 0 in cycle b)
  task automatic exp_frame(input int b, input logic [7:0] w0);
    exp_ev(EV_SPI, 8'h00, b + 1);
    exp_ev(EV_WORD, w0, b + 5);
    exp_ev(EV_WORD, w0 + 8'd1, b + 6);
    exp_ev(EV_WORD, w0 + 8'd2, b + 7);
    exp_ev(EV_BD, 8'h00, b + 8);
  endtask

  task automatic got_ev(input int kind, input logic [7:0] d);
    ev_t e;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got %s data=%02h cycle=%0d, expected no event",
               kname(kind), d, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind || e.data != d || e.at != cyc) begin
        n_fail++;
        $display("FAIL sb_event: got %s data=%02h cycle=%0d, expected %s data=%02h cycle=%0d",
                 kname(kind), d, cyc, kname(e.kind), e.data, e.at);
      end
    end
  endtask

  // Sample on the falling edge, report every output event to the scoreboard
  task automatic monitor();
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", 32'({dv, tx_data}), 32'({1'b1, prev_d}));
        if (spi_reset)      got_ev(EV_SPI, 8'h00);
        if (overrun)        got_ev(EV_OVR, 8'h00);
        if (dv && tx_ready) got_ev(EV_WORD, tx_data);
        if (burst_done)     got_ev(EV_BD, 8'h00);
        prev_stall = dv && !tx_ready;
        prev_d     = tx_data;
      end
    end
  endtask

  // Advance to cycle x; inputs change 1 time unit after the rising edge
  task automatic tick_to(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;
    tick_to(3);
    chk("rst_spi_reset",  32'(spi_reset),  32'd0);
    chk("rst_dv",         32'(dv),         32'd0);
    chk("rst_tx_data",    32'(tx_data),    32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_overrun",    32'(overrun),    32'd0);
    rst_n = 1'b1;
    tick_to(cyc + 2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Periodic mode, two full frames: F0..F2 then F3..F5
    base = cyc + 1;
    exp_frame(base, 8'hF0);
    exp_frame(base + 16, 8'hF3);
    en = 1'b1;
    tick_to(base + 2);
    chk("periodic_busy", 32'(busy), 32'd1);
    tick_to(base + 26);
    en = 1'b0;
    tick_to(base + 27);
    chk("periodic_stop_busy", 32'(busy), 32'd0);

    // Back-pressure: 2nd word (F7) stalled for 5 cycles
    tick_to(cyc + 2);
    base = cyc + 1;
    exp_ev(EV_SPI, 8'h00, base + 1);
    exp_ev(EV_WORD, 8'hF6, base + 5);
    exp_ev(EV_WORD, 8'hF7, base + 11);
    exp_ev(EV_WORD, 8'hF8, base + 12);
    exp_ev(EV_BD, 8'h00, base + 13);
    en = 1'b1;
    tick_to(base + 6);
    tx_ready = 1'b0;
    tick_to(base + 11);
    tx_ready = 1'b1;
    tick_to(base + 15);
    en = 1'b0;
    tick_to(base + 16);
    chk("bp_stop_busy", 32'(busy), 32'd0);

    // Overrun: count freezes at 15, then en=0 mid-burst in the next frame
    tick_to(cyc + 2);
    base = cyc + 1;
    exp_ev(EV_SPI, 8'h00, base + 1);
    exp_ev(EV_WORD, 8'hF9, base + 5);
    exp_ev(EV_OVR, 8'h00, base + 16);
    exp_ev(EV_WORD, 8'hFA, base + 18);
    exp_ev(EV_WORD, 8'hFB, base + 19);
    exp_ev(EV_BD, 8'h00, base + 20);
    exp_ev(EV_SPI, 8'h00, base + 21);
    exp_ev(EV_WORD, 8'hFC, base + 25);
    exp_ev(EV_WORD, 8'hFD, base + 27);
    en = 1'b1;
    tick_to(base + 6);
    tx_ready = 1'b0;
    tick_to(base + 17);
    chk("ovr_frozen_busy", 32'(busy), 32'd1);
    tick_to(base + 18);
    tx_ready = 1'b1;
    tick_to(base + 26);
    tx_ready = 1'b0;
    en = 1'b0;
    tick_to(base + 27);
    tx_ready = 1'b1;
    tick_to(base + 28);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dv",   32'(dv),   32'd0);

    // Word-counter wrap: FE, FF, 00
    tick_to(cyc + 2);
    base = cyc + 1;
    exp_frame(base, 8'hFE);
    en = 1'b1;
    tick_to(base + 10);
    en = 1'b0;
    tick_to(base + 11);
    chk("wrap_stop_busy", 32'(busy), 32'd0);

    // One-shot: one frame, second start and a mode change while busy ignored
    tick_to(cyc + 2);
    base = cyc + 1;
    exp_frame(base, 8'h01);
    mode  = 1'b1;
    start = 1'b1;
    en    = 1'b1;
    tick_to(base);
    start = 1'b0;
    tick_to(base + 10);
    start = 1'b1;
    tick_to(base + 11);
    start = 1'b0;
    mode  = 1'b0;
    tick_to(base + 15);
    chk("oneshot_busy_end", 32'(busy), 32'd1);
    tick_to(base + 16);
    mode = 1'b1;
    en   = 1'b0;
    chk("oneshot_idle", 32'(busy), 32'd0);
    tick_to(base + 20);
    chk("oneshot_stay_idle", 32'(busy), 32'd0);

    // Async reset mid-burst, then a fresh burst from SEED
    mode = 1'b0;
    tick_to(cyc + 2);
    base = cyc + 1;
    exp_ev(EV_SPI, 8'h00, base + 1);
    exp_ev(EV_WORD, 8'h04, base + 5);
    en = 1'b1;
    tick_to(base + 6);
    tx_ready = 1'b0;
    tick_to(base + 7);
    chk("pre_rst_dv",      32'(dv),      32'd1);
    chk("pre_rst_tx_data", 32'(tx_data), 32'h05);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_spi_reset",  32'(spi_reset),  32'd0);
    chk("async_dv",         32'(dv),         32'd0);
    chk("async_tx_data",    32'(tx_data),    32'd0);
    chk("async_busy",       32'(busy),       32'd0);
    chk("async_burst_done", 32'(burst_done), 32'd0);
    chk("async_overrun",    32'(overrun),    32'd0);
    tick_to(base + 9);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    base = base + 10;
    exp_frame(base, 8'hF0);
    tick_to(base + 10);
    en = 1'b0;
    tick_to(base + 12);
    chk("final_busy", 32'(busy), 32'd0);

    tick_to(cyc + 4);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_tx_seq_cntrl
